// File: rtl/seg_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_disp_pkg
// Shared types and constants for the six-digit seven-segment display path.
//   state_t      : arbiter FSM states (S_IDLE, S_SHOW)
//   SEG_DIGITS   : number of display digits
//   SEG_NIB_W    : bits per digit nibble
//   SEG_VAL_W    : bits per requester value (SEG_DIGITS * SEG_NIB_W)
//   N_REQ        : number of display requesters (also used by the driver side)
//   onehot_idx() : converts a 3-bit one-hot grant into its requester index
// ---------------------------------------------------------------------------
package seg_disp_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    localparam int SEG_DIGITS = 6;
    localparam int SEG_NIB_W  = 4;
    localparam int SEG_VAL_W  = 24;
    localparam int N_REQ      = 3;

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational winner selection for the display arbiter.
// Build option: SEG_DISP_ARB_RR_EN
//   defined   : round-robin, search starts at the requester after 'last'
//               and wraps 2 -> 0.
//   undefined : fixed priority, requester 0 highest; 'last' port absent.
// Ports:
//   req   in  3 : level requests
//   last  in  2 : index of the last granted requester (round-robin only)
//   win   out 3 : one-hot winner, zero when no request
//   valid out 1 : at least one request present
// ---------------------------------------------------------------------------
module rr_pick (
    input  logic [2:0] req,
`ifdef SEG_DISP_ARB_RR_EN
    input  logic [1:0] last,
`endif
    output logic [2:0] win,
    output logic       valid
);

    always_comb begin
        win   = 3'b000;
        valid = |req;
`ifdef SEG_DISP_ARB_RR_EN
        // Candidate order is the three requesters rotated to start after 'last'.
        case (last)
            2'd0: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd1: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
`else
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
`endif
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// ---------------------------------------------------------------------------
// seg_disp_arbiter
// Shares the six-digit display between three requesters. A winner's value is
// latched into the hex registers and owns the display for HOLD_CYC cycles;
// at expiry the arbiter re-arbitrates in the same cycle (no idle gap) or
// returns to idle, keeping the last value on the display.
// Build option: SEG_DISP_ARB_RR_EN (round-robin when defined, otherwise
// fixed priority with requester 0 highest).
// Parameters:
//   HOLD_CYC : minimum display ownership in clk cycles (>= 1)
//   N_REQ    : number of requesters (3)
// Ports:
//   clk            in  1  : system clock
//   rst            in  1  : synchronous active-low reset
//   req            in  3  : level requests
//   data0..data2   in  24 : requester values, [3:0] -> digit 0
//   gnt            out 3  : one-hot display owner, zero when idle
//   ack            out 3  : one-cycle pulse when data_i is latched
//   busy           out 1  : high while showing
//   hex0..hex5     out 4  : latched digit nibbles
// ---------------------------------------------------------------------------
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int HOLD_CYC = 30_000_000,
    parameter int N_REQ    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic [23:0] data2,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic        busy,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic [3:0]  hex4,
    output logic [3:0]  hex5
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2:0]             gnt_reg;
    logic [2:0]             ack_reg;
    logic                   busy_reg;
    logic [SEG_VAL_W-1:0]   hex_reg;

    logic [2:0]             pick_win;
    logic                   pick_valid;
    logic [SEG_VAL_W-1:0]   data_arr   [N_REQ];
    logic [SEG_VAL_W-1:0]   masked_arr [N_REQ];
    logic [SEG_VAL_W-1:0]   sel_data;
    logic [SEG_NIB_W-1:0]   nib        [SEG_DIGITS];

    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;

`ifdef SEG_DISP_ARB_RR_EN
    logic [1:0] ptr_reg;

    rr_pick u_pick (
        .req   (req),
        .last  (ptr_reg),
        .win   (pick_win),
        .valid (pick_valid)
    );
`else
    rr_pick u_pick (
        .req   (req),
        .win   (pick_win),
        .valid (pick_valid)
    );
`endif

    // One-hot AND-OR mux of the winner's data.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign masked_arr[gi] = pick_win[gi] ? data_arr[gi] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data = sel_data | masked_arr[i];
        end
    end

    // IDLE and SHOW-at-expiry behave identically: grant if anything is
    // requesting, otherwise (re)enter IDLE with the display value kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
            hex_reg   <= '0;
`ifdef SEG_DISP_ARB_RR_EN
            ptr_reg   <= 2'd2;
`endif
        end else begin
            ack_reg <= '0;
            if (state_reg == S_IDLE || cnt_reg == '0) begin
                if (pick_valid) begin
                    state_reg <= S_SHOW;
                    busy_reg  <= 1'b1;
                    gnt_reg   <= pick_win;
                    ack_reg   <= pick_win;
                    hex_reg   <= sel_data;
                    cnt_reg   <= CNT_LOAD;
`ifdef SEG_DISP_ARB_RR_EN
                    ptr_reg   <= onehot_idx(pick_win);
`endif
                end else begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    gnt_reg   <= '0;
                end
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SEG_DIGITS; gi++) begin : g_nib
            assign nib[gi] = hex_reg[gi*SEG_NIB_W +: SEG_NIB_W];
        end
    endgenerate

    assign gnt  = gnt_reg;
    assign ack  = ack_reg;
    assign busy = busy_reg;
    assign hex0 = nib[0];
    assign hex1 = nib[1];
    assign hex2 = nib[2];
    assign hex3 = nib[3];
    assign hex4 = nib[4];
    assign hex5 = nib[5];

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_disp_arbiter
// Table-driven bench for seg_disp_arbiter with HOLD_CYC = 4. Each table row
// is one clock: inputs driven on the falling edge, outputs checked 1 ns after
// the following rising edge. Expectations follow the build option
// SEG_DISP_ARB_RR_EN (round-robin) or its absence (fixed priority).
// ---------------------------------------------------------------------------
module tb_seg_disp_arbiter;

    localparam int HOLD = 4;

    localparam logic [23:0] D0  = 24'h123456;
    localparam logic [23:0] D0B = 24'h654321;
    localparam logic [23:0] D1  = 24'hABCDEF;
    localparam logic [23:0] D2  = 24'h0F1E2D;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] data0, data1, data2;
    logic [2:0]  gnt, ack;
    logic        busy;
    logic [3:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    seg_disp_arbiter #(
        .HOLD_CYC (HOLD),
        .N_REQ    (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .hex4  (hex4),
        .hex5  (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [23:0] d0;
        logic [2:0]  gnt;
        logic [2:0]  ack;
        logic        busy;
        logic [23:0] hex;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic r, input logic [2:0] rq, input logic [23:0] d,
                       input logic [2:0] g, input logic [2:0] a, input logic b,
                       input logic [23:0] h);
        vec_t v;
        v.rst = r; v.req = rq; v.d0 = d;
        v.gnt = g; v.ack = a; v.busy = b; v.hex = h;
        vecs.push_back(v);
    endtask

    function automatic logic [23:0] data_of(input logic [2:0] w);
        logic [23:0] d;
        d = D0;
        if (w == 3'b010) d = D1;
        if (w == 3'b100) d = D2;
        return d;
    endfunction

    function automatic logic [23:0] hex_now();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    initial begin
        logic [2:0] order[4];
        logic [2:0] w;
        logic [23:0] h;
        int n_gnt, n_ack;

        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        req   = 3'b000;
        data0 = D0;
        data1 = D1;
        data2 = D2;

`ifdef SEG_DISP_ARB_RR_EN
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
`else
        order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001; order[3] = 3'b001;
`endif

        // Reset and idle
        repeat (2) add(1'b0, 3'b000, D0, 3'b000, 3'b000, 1'b0, 24'h0);
        repeat (10) add(1'b1, 3'b000, D0, 3'b000, 3'b000, 1'b0, 24'h0);

        // Single request, 4-cycle hold, then idle with value kept
        add(1'b1, 3'b001, D0, 3'b001, 3'b001, 1'b1, D0);
        repeat (3) add(1'b1, 3'b000, D0, 3'b001, 3'b000, 1'b1, D0);
        repeat (3) add(1'b1, 3'b000, D0, 3'b000, 3'b000, 1'b0, D0);

        // Owner keeps requesting: data frozen during hold, re-latched at expiry
        add(1'b1, 3'b001, D0, 3'b001, 3'b001, 1'b1, D0);
        repeat (3) add(1'b1, 3'b001, D0B, 3'b001, 3'b000, 1'b1, D0);
        add(1'b1, 3'b001, D0B, 3'b001, 3'b001, 1'b1, D0B);
        repeat (3) add(1'b1, 3'b000, D0B, 3'b001, 3'b000, 1'b1, D0B);
        add(1'b1, 3'b000, D0B, 3'b000, 3'b000, 1'b0, D0B);

        // All requesting from reset: back-to-back grants without a gap
        add(1'b0, 3'b000, D0, 3'b000, 3'b000, 1'b0, 24'h0);
        h = 24'h0;
        for (int b = 0; b < 4; b++) begin
            w = order[b];
            h = data_of(w);
            add(1'b1, 3'b111, D0, w, w, 1'b1, h);
            repeat (3) add(1'b1, 3'b111, D0, w, 3'b000, 1'b1, h);
        end
        add(1'b1, 3'b000, D0, 3'b000, 3'b000, 1'b0, h);

        // Early withdrawal by requester 1
        add(1'b1, 3'b010, D0, 3'b010, 3'b010, 1'b1, D1);
        repeat (3) add(1'b1, 3'b000, D0, 3'b010, 3'b000, 1'b1, D1);
        add(1'b1, 3'b000, D0, 3'b000, 3'b000, 1'b0, D1);

        // Reset in the middle of a hold
        add(1'b1, 3'b100, D0, 3'b100, 3'b100, 1'b1, D2);
        add(1'b1, 3'b100, D0, 3'b100, 3'b000, 1'b1, D2);
        add(1'b0, 3'b100, D0, 3'b000, 3'b000, 1'b0, 24'h0);
        add(1'b1, 3'b000, D0, 3'b000, 3'b000, 1'b0, 24'h0);
        add(1'b1, 3'b100, D0, 3'b100, 3'b100, 1'b1, D2);
        add(1'b0, 3'b000, D0, 3'b000, 3'b000, 1'b0, 24'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            req   = vecs[i].req;
            data0 = vecs[i].d0;
            @(posedge clk);
            #1;
            n_vec++;
            if ({gnt, ack, busy, hex_now()} !== {vecs[i].gnt, vecs[i].ack, vecs[i].busy, vecs[i].hex}) begin
                n_bad++;
                $display("FAIL vec %0d: got gnt=%b ack=%b busy=%b hex=%h, expected gnt=%b ack=%b busy=%b hex=%h",
                         i, gnt, ack, busy, hex_now(),
                         vecs[i].gnt, vecs[i].ack, vecs[i].busy, vecs[i].hex);
            end else begin
                $display("ok   vec %0d: req=%b gnt=%b ack=%b busy=%b hex=%h",
                         i, vecs[i].req, gnt, ack, busy, hex_now());
            end
        end

        // One-cycle request pulse: exactly HOLD cycles of gnt and one ack
        @(negedge clk);
        rst   = 1'b1;
        data0 = D0;
        req   = 3'b001;
        n_gnt = 0;
        n_ack = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (gnt == 3'b001) n_gnt++;
            if (ack != 3'b000) n_ack++;
            @(negedge clk);
            req = 3'b000;
        end
        check("pulse_gnt_cycles", 32'(n_gnt), 32'(HOLD));
        check("pulse_ack_count", 32'(n_ack), 32'd1);
        check("pulse_end_state", {4'h0, 1'b0, gnt, busy, hex_now()}, {4'h0, 1'b0, 3'b000, 1'b0, D0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
